// File: rtl/led_cmd_arb.sv
// led_cmd_arb: two-source arbiter (TWI register path, firmware API path) feeding
// the LED controller's single reg_din/vld command interface.
//
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   twi_req/twi_data/twi_mask   TWI request (level), 8x4-bit mode word, nibble enables
//   twi_ack                     one-cycle accept pulse to TWI
//   api_req/api_data/api_mask   API request (level), mode word, nibble enables
//   api_ack                     one-cycle accept pulse to API
//   reg_din                     shadow LED mode word, changes only in the ACK cycle
//   vld                         one-cycle command strobe, followed by GAP_CYC idle cycles
//   busy                        high whenever the arbiter is not in IDLE
//
// Timing: request seen in IDLE at T0 -> ack and new reg_din at T1, vld at T2,
// GAP for GAP_CYC cycles, back in IDLE at T3+GAP_CYC.
module led_cmd_arb #(
  parameter int GAP_CYC = 32,
  parameter int GAP_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        twi_req,
  input  logic [31:0] twi_data,
  input  logic [7:0]  twi_mask,
  output logic        twi_ack,
  input  logic        api_req,
  input  logic [31:0] api_data,
  input  logic [7:0]  api_mask,
  output logic        api_ack,
  output logic [31:0] reg_din,
  output logic        vld,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACK, ISSUE, GAP} state_t;

  localparam logic SRC_TWI = 1'b0;
  localparam logic SRC_API = 1'b1;

  state_t             state, state_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic               last_grant, last_n;
  logic               mask_nz, mask_nz_n;   // granted mask was non-zero -> issue vld
  logic               twi_ack_n, api_ack_n, vld_n, busy_n;
  logic [31:0]        din_n;

  logic               grant_twi, grant_api;
  logic [31:0]        sel_data, merged;
  logic [7:0]         sel_mask;

  // Round-robin on a tie: the source that did not win last time goes first.
  assign grant_twi = twi_req && (!api_req || (last_grant == SRC_API));
  assign grant_api = api_req && !grant_twi;

  assign sel_data = grant_twi ? twi_data : api_data;
  assign sel_mask = grant_twi ? twi_mask : api_mask;

  always_comb begin
    merged = reg_din;
    for (int i = 0; i < 8; i++)
      if (sel_mask[i]) merged[4*i +: 4] = sel_data[4*i +: 4];
  end

  // All outputs are registered: the decision taken in IDLE lands ack and
  // reg_din together in the ACK cycle, so reg_din is stable a cycle before vld.
  always_comb begin
    state_n   = state;
    gap_n     = gap_cnt;
    last_n    = last_grant;
    mask_nz_n = mask_nz;
    din_n     = reg_din;
    twi_ack_n = 1'b0;
    api_ack_n = 1'b0;
    vld_n     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_twi || grant_api) begin
          state_n   = ACK;
          twi_ack_n = grant_twi;
          api_ack_n = grant_api;
          din_n     = merged;
          last_n    = grant_twi ? SRC_TWI : SRC_API;
          mask_nz_n = |sel_mask;
        end
      end
      ACK: begin
        // Empty mask: the requester is still acknowledged but no shift is started.
        if (mask_nz) begin
          state_n = ISSUE;
          vld_n   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        state_n = GAP;
        gap_n   = GAP_W'(GAP_CYC - 1);
      end
      GAP: begin
        if (gap_cnt == '0) state_n = IDLE;
        else               gap_n   = gap_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      last_grant <= SRC_API;
      mask_nz    <= 1'b0;
      reg_din    <= '0;
      twi_ack    <= 1'b0;
      api_ack    <= 1'b0;
      vld        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      gap_cnt    <= gap_n;
      last_grant <= last_n;
      mask_nz    <= mask_nz_n;
      reg_din    <= din_n;
      twi_ack    <= twi_ack_n;
      api_ack    <= api_ack_n;
      vld        <= vld_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_led_cmd_arb.sv
module tb_led_cmd_arb;

  localparam int GAP_CYC = 32;
  localparam int GAP_W   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        twi_req, api_req;
  logic [31:0] twi_data, api_data;
  logic [7:0]  twi_mask, api_mask;
  logic        twi_ack, api_ack, vld, busy;
  logic [31:0] reg_din;

  int checks = 0;
  int errors = 0;

  led_cmd_arb #(.GAP_CYC(GAP_CYC), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst),
    .twi_req(twi_req), .twi_data(twi_data), .twi_mask(twi_mask), .twi_ack(twi_ack),
    .api_req(api_req), .api_data(api_data), .api_mask(api_mask), .api_ack(api_ack),
    .reg_din(reg_din), .vld(vld), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic src, input logic req, input logic [31:0] d, input logic [7:0] m);
    if (src) begin api_req = req; api_data = d; api_mask = m; end
    else     begin twi_req = req; twi_data = d; twi_mask = m; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 200; n++) begin
      if (!busy) break;
      tick();
    end
    chk("wait_idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  typedef struct {
    logic        src;      // 0 = TWI, 1 = API
    logic [31:0] data;
    logic [7:0]  mask;
    logic [31:0] exp_din;
    logic        exp_vld;
  } vec_t;

  // Full handshake for one request from an idle arbiter, checking ack latency,
  // merged word, vld pulse and GAP length.
  task automatic do_txn(input vec_t v);
    int n;
    logic got;
    wait_idle();
    drive(v.src, 1'b1, v.data, v.mask);
    got = 1'b0;
    for (n = 1; n <= 10; n++) begin
      tick();
      if (v.src ? api_ack : twi_ack) begin got = 1'b1; break; end
    end
    chk("ack_latency", got ? n : 99, 1);
    chk("din_at_ack", reg_din, v.exp_din);
    chk("vld_at_ack", {31'b0, vld}, 32'd0);
    chk("other_ack", {31'b0, v.src ? twi_ack : api_ack}, 32'd0);
    drive(v.src, 1'b0, v.data, v.mask);
    tick();
    chk("vld_issue", {31'b0, vld}, {31'b0, v.exp_vld});
    chk("ack_single", {30'b0, twi_ack, api_ack}, 32'd0);
    chk("busy_after_ack", {31'b0, busy}, {31'b0, v.exp_vld});
    if (v.exp_vld) begin
      for (n = 0; n < 100; n++) begin
        tick();
        if (vld) chk("vld_single", 32'd1, 32'd0);
        if (!busy) break;
      end
      chk("gap_len", n, GAP_CYC);
      chk("din_hold", reg_din, v.exp_din);
    end
  endtask

  vec_t vecs[5];

  initial begin
    int n, v0, ack_at, vcount, gcount;
    logic [31:0] vld_t[4];
    logic        gsrc[4];
    logic        prev_vld, prev_twi, prev_api;

    twi_req = 0; api_req = 0; twi_data = 0; api_data = 0; twi_mask = 0; api_mask = 0;
    do_reset();
    tick();
    chk("rst_reg_din", reg_din, 32'h0);
    chk("rst_outputs", {28'b0, twi_ack, api_ack, vld, busy}, 32'd0);

    vecs[0] = '{1'b0, 32'h1111_1111, 8'hFF, 32'h1111_1111, 1'b1};
    vecs[1] = '{1'b1, 32'h2222_2222, 8'h0F, 32'h1111_2222, 1'b1};
    vecs[2] = '{1'b1, 32'h3333_3333, 8'h00, 32'h1111_2222, 1'b0};
    vecs[3] = '{1'b0, 32'hABCD_EF01, 8'hA5, 32'hA1C1_2F21, 1'b1};
    vecs[4] = '{1'b1, 32'hA1C1_2F21, 8'hFF, 32'hA1C1_2F21, 1'b1};
    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

    // Both sources requesting continuously from reset: strict alternation,
    // TWI first, vld spacing GAP_CYC+3.
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h5555_5555, 8'hFF);
    drive(1'b1, 1'b1, 32'h6666_6666, 8'hFF);
    tick(); tick();
    rst = 1'b0;
    vcount = 0; gcount = 0; prev_vld = 0; prev_twi = 0; prev_api = 0;
    for (n = 0; n < 400 && vcount < 4; n++) begin
      tick();
      if (twi_ack && api_ack) chk("dual_ack", 32'd1, 32'd0);
      if ((vld && prev_vld) || (twi_ack && prev_twi) || (api_ack && prev_api))
        chk("pulse_width", 32'd2, 32'd1);
      if ((twi_ack || api_ack) && gcount < 4) begin
        gsrc[gcount] = api_ack;
        chk("rr_din", reg_din, api_ack ? 32'h6666_6666 : 32'h5555_5555);
        gcount++;
      end
      if (vld) begin vld_t[vcount] = n; vcount++; end
      prev_vld = vld; prev_twi = twi_ack; prev_api = api_ack;
    end
    chk("rr_vld_count", vcount, 4);
    for (int k = 0; k < 4; k++)
      if (k < gcount) chk("rr_order", {31'b0, gsrc[k]}, {31'b0, k[0]});
    for (int k = 1; k < 4; k++)
      if (k < vcount) chk("rr_spacing", vld_t[k] - vld_t[k-1], GAP_CYC + 3);
    drive(1'b0, 1'b0, 32'h0, 8'h0);
    drive(1'b1, 1'b0, 32'h0, 8'h0);
    wait_idle();
    tick();

    // TWI request raised 5 cycles into GAP waits for IDLE.
    drive(1'b0, 1'b1, 32'h7777_7777, 8'hFF);
    v0 = -1;
    for (n = 0; n < 50; n++) begin
      tick();
      if (twi_ack) drive(1'b0, 1'b0, 32'h7777_7777, 8'hFF);
      if (vld) begin v0 = n; break; end
    end
    chk("gapreq_first_vld", {31'b0, v0 >= 0}, 32'd1);
    ack_at = -1;
    for (n = 1; n < 100; n++) begin
      tick();
      if (n == 5) drive(1'b0, 1'b1, 32'h8888_8888, 8'hFF);
      if (twi_ack) begin ack_at = n; break; end
    end
    chk("gapreq_ack_time", ack_at, GAP_CYC + 2);
    chk("gapreq_din", reg_din, 32'h8888_8888);
    drive(1'b0, 1'b0, 32'h0, 8'h0);

    // Reset while the gap counter holds 10: everything clears, tie goes to TWI.
    wait_idle();
    tick();
    drive(1'b1, 1'b1, 32'h9999_9999, 8'hFF);
    v0 = -1;
    for (n = 0; n < 50; n++) begin
      tick();
      if (api_ack) drive(1'b1, 1'b0, 32'h9999_9999, 8'hFF);
      if (vld) begin v0 = n; break; end
    end
    chk("rstgap_vld", {31'b0, v0 >= 0}, 32'd1);
    for (n = 0; n < 22; n++) tick();
    chk("rstgap_cnt", {24'b0, dut.gap_cnt}, 32'd10);
    rst = 1'b1;
    tick();
    chk("rstgap_busy", {31'b0, busy}, 32'd0);
    chk("rstgap_din", reg_din, 32'h0);
    chk("rstgap_vld0", {31'b0, vld}, 32'd0);
    drive(1'b0, 1'b1, 32'hAAAA_AAAA, 8'hFF);
    drive(1'b1, 1'b1, 32'hBBBB_BBBB, 8'hFF);
    rst = 1'b0;
    ack_at = -1;
    for (n = 1; n < 10; n++) begin
      tick();
      if (twi_ack || api_ack) begin ack_at = n; break; end
    end
    chk("rstgap_tie_twi", {30'b0, twi_ack, api_ack}, 32'd2);
    chk("rstgap_tie_din", reg_din, 32'hAAAA_AAAA);
    drive(1'b0, 1'b0, 32'h0, 8'h0);
    drive(1'b1, 1'b0, 32'h0, 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
